ps2_rx: RTL
===========

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the number of clk cycles without a ps2_clk falling edge that aborts a partial frame.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have port ps2_clk, input, 1, raw PS/2 clock line, asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1, raw PS/2 data line, asynchronous to clk.
REQ-006 SHALL have port key, output, 8, last accepted scan code byte, for the downstream scan-code-to-decimal decoder.
REQ-007 SHALL have port key_valid, output, 1, one-cycle strobe marking that key was updated.
REQ-008 SHALL have port frame_err, output, 1, one-cycle strobe on a parity, stop or timeout failure.

Function
REQ-009 SHALL synchronise ps2_clk and ps2_data through two flops each before any use.
REQ-010 SHALL detect a falling edge when the synchronised ps2_clk was 1 in the previous cycle and is 0 in the current one.
REQ-011 SHALL implement states IDLE, DATA, PARITY and STOP, with all sampling done only on detected falling edges.
REQ-012 IDLE: an edge with data=0 (start bit) SHALL clear the bit counter and go to DATA; an edge with data=1 SHALL be ignored.
REQ-013 DATA: SHALL shift in 8 bits LSB first and go to PARITY after the 8th bit.
REQ-014 PARITY: SHALL sample the parity bit and go to STOP; the frame is good only if the 8 data bits plus the parity bit contain an odd number of ones.
REQ-015 STOP: stop bit SHALL be 1; the block SHALL always return to IDLE after the stop edge.
REQ-016 On a good frame, key SHALL update and key_valid SHALL pulse high for exactly one cycle, in the cycle after the stop-bit edge is detected.
REQ-017 On bad parity or stop=0, frame_err SHALL pulse for one cycle, key SHALL remain unchanged and key_valid SHALL stay low.
REQ-018 In any non-IDLE state, a cycle counter SHALL clear on every detected edge and increment otherwise.
REQ-019 When the counter reaches TIMEOUT_CYCLES, the block SHALL go to IDLE and pulse frame_err.
REQ-020 If a timeout and an edge occur in the same cycle, the edge SHALL win and no timeout SHALL occur.
REQ-021 Between strobes, key SHALL hold its value; key_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-022 While rst_n=0: state=IDLE; key=8'h00; key_valid=0; frame_err=0; counters, synchroniser flops (to 1) and break_pending cleared.
REQ-023 Reset mid-frame SHALL discard the partial frame without a frame_err pulse.

Configuration
REQ-024 With macro PS2_BREAK_FILTER_EN defined:
- a good byte 8'hF0 SHALL set break_pending and SHALL NOT pulse key_valid;
- the next good byte SHALL clear break_pending, SHALL NOT update key and SHALL NOT pulse key_valid;
- frame errors SHALL leave break_pending unchanged.
REQ-025 Without PS2_BREAK_FILTER_EN, every good byte, including F0, SHALL be delivered, and no break_pending state SHALL exist.

Structure
REQ-026 A package ps2_pkg SHALL hold the state enum and the constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0.
REQ-027 The sub-module ps2_sync SHALL contain the two-flop synchronisers and the falling-edge detector; the FSM, counters and filter SHALL live in ps2_rx.

Verification
REQ-028 Frame for 8'h16 with parity 0 and stop 1 -> key=8'h16, one key_valid pulse, frame_err=0.
REQ-029 Frame for 8'h45 with parity 1 (wrong) -> one frame_err pulse, key unchanged, no key_valid.
REQ-030 With PS2_BREAK_FILTER_EN, frames F0 then 1E -> no key_valid, key unchanged; a following 26 -> key=8'h26 with a key_valid pulse.
REQ-031 Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES -> one frame_err pulse; a following good 8'h3D frame -> key=8'h3D.
REQ-032 rst_n asserted after 5 bits, released, then a good 8'h46 frame -> no frame_err, key=8'h46 with a key_valid pulse.
REQ-033 A ps2_clk edge landing in the same cycle as a timeout -> no frame_err, and the frame continues.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ps2_pkg;

  // Frame FSM states; every transition happens on a detected ps2_clk fall.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Scan-code prefixes: F0 announces a key release, E0 an extended key.
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Output bundle of the PS/2 receiver towards the scan-code decoder.
// Latency: n/a (wires only).
// Backpressure: none; key_valid and frame_err are one-cycle strobes the sink must accept.
// Signals: key[7:0] last accepted scan code, key_valid update strobe, frame_err error strobe.
`timescale 1ns/1ps
interface ps2_rx_if;
  logic [7:0] key;
  logic       key_valid;
  logic       frame_err;

  modport master (output key, key_valid, frame_err);
  modport slave  (input  key, key_valid, frame_err);
endinterface

// File: rtl/ps2_sync.sv
// Two-flop synchronisers for the raw PS/2 lines plus a ps2_clk falling-edge detector.
// Latency: fall asserts in the 2nd cycle after ps2_clk drops at the input; data_s has the same delay.
// Backpressure: none; fall is a single-cycle pulse per edge.
// Ports: clk, rst_n (async, active-low); ps2_clk, ps2_data raw inputs;
//        fall edge pulse, data_s synchronised data line.
`timescale 1ns/1ps
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // Reset to 1 so the idle-high bus does not look like an edge on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Latency: key/key_valid (or frame_err) register in the cycle after the stop-bit edge is detected.
// Backpressure: none; strobes are single-cycle and must be consumed by the sink.
// Ports: clk, rst_n (async, active-low); ps2_clk, ps2_data raw PS/2 lines;
//        bus (ps2_rx_if.master): key, key_valid, frame_err.
// Build option: PS2_BREAK_FILTER_EN swallows F0 and the byte that follows it.
`timescale 1ns/1ps
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master bus
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          fall;
  logic          data_s;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    key_q;
  logic          key_valid_q;
  logic          frame_err_q;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending;
`endif

  ps2_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tmo_cnt     <= '0;
      key_q       <= 8'h00;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      // Idle-gap counter: only meaningful inside a frame.
      if (state == IDLE || fall) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (fall && !data_s) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (fall) begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par   <= data_s;
            state <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (data_s && parity_ok(shreg, par)) begin
`ifdef PS2_BREAK_FILTER_EN
              // F0 arms the filter; the released key's code is then dropped.
              if (shreg == BREAK_CODE) begin
                break_pending <= 1'b1;
              end else if (break_pending) begin
                break_pending <= 1'b0;
              end else begin
                key_q       <= shreg;
                key_valid_q <= 1'b1;
              end
`else
              key_q       <= shreg;
              key_valid_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // This cycle would be the TIMEOUT_CYCLES-th one without an edge.
      // An edge in the same cycle takes the branch above instead.
      if (state != IDLE && !fall && tmo_cnt == TMO_LAST) begin
        state       <= IDLE;
        tmo_cnt     <= '0;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule
